// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle for the bit-serial adder: operand channel, result channel
// and status taps, bundled so the controller and its driver share one port.
// Ports: in_valid/in_ready/a/b (operands), out_valid/out_ready/sum/cout
// (result), busy/bit_idx (status).
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic [CW-1:0]    bit_idx;

    // master drives operands and consumes results; slave is the controller
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, busy, bit_idx
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, busy, bit_idx
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders + carry reg) stepped LSB-first.
// Latency: WIDTH cycles from input handshake to out_valid; initiation interval WIDTH+2.
// Backpressure: in_ready only in IDLE; DONE holds sum/cout stable until out_ready.
// Ports: clk, rst (sync, active-high), bus (serial_add_ctrl_if.slave: in_valid/in_ready/a/b,
// out_valid/out_ready/sum/cout, busy, bit_idx).
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    bit_idx_q;

    logic             ha0_s;
    logic             ha0_c;
    logic             ha1_c;
    logic             cell_s;
    logic             cell_c;
    logic             accept;
    logic             last_bit;

    // Full-adder cell: half adder on the operand bits, second half adder
    // folds in the carry, OR of the two half-adder carries is the majority.
    always_comb begin
        ha0_s  = a_sh[0] ^ b_sh[0];
        ha0_c  = a_sh[0] & b_sh[0];
        cell_s = ha0_s ^ carry;
        ha1_c  = ha0_s & carry;
        cell_c = ha0_c | ha1_c;
    end

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_bit = (bit_idx_q == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)      state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            sum_q     <= '0;
            carry     <= 1'b0;
            cout_q    <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh      <= bus.a;
                b_sh      <= bus.b;
                carry     <= 1'b0;
                bit_idx_q <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
                carry  <= cell_c;
                if (last_bit) begin
                    // Publish the result only on the RUN->DONE edge so the
                    // previous sum/cout stay visible while a new add runs.
                    sum_q     <= {cell_s, sum_sh[WIDTH-1:1]};
                    cout_q    <= cell_c;
                    bit_idx_q <= '0;
                end else begin
                    bit_idx_q <= bit_idx_q + CW'(1);
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.bit_idx   = bit_idx_q;

endmodule
